// File: rtl/matrix_operand_loader_if.sv
// Stream-in and operand-out bundle between the element feeder, the operand
// loader and the matrix multiplier. The feeder drives the element stream and
// the control pulses. The loader drives the handshake ready, the packed
// operands and the multiplier control.
interface matrix_operand_loader_if #(
  parameter int aRow  = 4,
  parameter int aCol  = 4,
  parameter int bRow  = 4,
  parameter int bCol  = 2,
  parameter int elemW = 8
) ();

  localparam int MATRIX_A_LEN = aRow * aCol * elemW;
  localparam int MATRIX_B_LEN = bRow * bCol * elemW;

  // Element stream (valid/ready)
  logic [elemW-1:0]        inData;
  logic                    inValid;
  logic                    inReady;

  // Control from downstream
  logic                    flush;
  logic                    resAck;

  // Packed operands and multiplier control
  logic [MATRIX_A_LEN-1:0] a;
  logic [MATRIX_B_LEN-1:0] b;
  logic                    multRst;
  logic                    loadDone;
  logic [7:0]              loadCount;

  // Feeder / consumer side
  modport master (
    output inData, inValid, flush, resAck,
    input  inReady, a, b, multRst, loadDone, loadCount
  );

  // Loader side
  modport slave (
    input  inData, inValid, flush, resAck,
    output inReady, a, b, multRst, loadDone, loadCount
  );

endinterface

// File: rtl/matrix_operand_loader.sv
// Matrix operand loader: collects a byte stream holding all of A and then all
// of B (each row-major). It shifts the elements into the flat operand buses,
// so the first element lands in the MSBs. The multiplier is held in reset
// until both operands are complete. The loader then re-arms when the
// downstream stage acknowledges the result.
module matrix_operand_loader #(
  parameter int aRow  = 4,
  parameter int aCol  = 4,
  parameter int bRow  = 4,
  parameter int bCol  = 2,
  parameter int elemW = 8
) (
  input  logic                  clk,
  input  logic                  rst,   // asynchronous, active low
  matrix_operand_loader_if.slave bus
);

  localparam int MATRIX_A_LEN = aRow * aCol * elemW;
  localparam int MATRIX_B_LEN = bRow * bCol * elemW;

  // Index of the last element of each operand, in loadCount's width.
  localparam logic [7:0] A_LAST = 8'(aRow * aCol - 1);
  localparam logic [7:0] B_LAST = 8'(bRow * bCol - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                  state_q,     state_d;
  logic [MATRIX_A_LEN-1:0] a_q,         a_d;
  logic [MATRIX_B_LEN-1:0] b_q,         b_d;
  logic [7:0]              count_q,     count_d;
  logic                    mult_rst_q,  mult_rst_d;
  logic                    load_done_q, load_done_d;

  logic                    in_ready;
  logic                    xfer;

  // Next-state decode: flush beats everything, then per-state load/run handling.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned; without these the tool infers latches.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    count_d     = count_q;
    mult_rst_d  = mult_rst_q;
    load_done_d = load_done_q;

    in_ready    = (state_q != RUN);
    xfer        = bus.inValid & in_ready;

    if (bus.flush) begin
      // Abort: drop any offered element and return to a clean LOAD_A.
      state_d     = LOAD_A;
      a_d         = '0;
      b_d         = '0;
      count_d     = '0;
      mult_rst_d  = 1'b0;
      load_done_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (xfer) begin
            a_d = {a_q[MATRIX_A_LEN-elemW-1:0], bus.inData};
            if (count_q == A_LAST) begin
              state_d = LOAD_B;
              count_d = '0;
            end else begin
              count_d = count_q + 8'd1;
            end
          end
        end

        LOAD_B: begin
          if (xfer) begin
            b_d = {b_q[MATRIX_B_LEN-elemW-1:0], bus.inData};
            if (count_q == B_LAST) begin
              // Both operands complete: release the multiplier.
              state_d     = RUN;
              count_d     = '0;
              mult_rst_d  = 1'b1;
              load_done_d = 1'b1;
            end else begin
              count_d = count_q + 8'd1;
            end
          end
        end

        RUN: begin
          // Operands frozen. Only the result acknowledge moves us on. a and b
          // are left in place until the next load shifts them out.
          if (bus.resAck) begin
            state_d     = LOAD_A;
            mult_rst_d  = 1'b0;
            load_done_d = 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: recover the same way a flush would.
          state_d     = LOAD_A;
          a_d         = '0;
          b_d         = '0;
          count_d     = '0;
          mult_rst_d  = 1'b0;
          load_done_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments in clocked blocks keep every flop
      // sampling the pre-edge values of the others, so order does not matter.
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      count_q     <= '0;
      mult_rst_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      count_q     <= count_d;
      mult_rst_q  <= mult_rst_d;
      load_done_q <= load_done_d;
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.loadCount = count_q;
  assign bus.multRst   = mult_rst_q;
  assign bus.loadDone  = load_done_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader. Inputs change on the falling edge
// and outputs are sampled on the following falling edge.
module tb_matrix_operand_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  matrix_operand_loader_if bus ();

  matrix_operand_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [7:0] exp_count;
    logic       exp_done;
    logic       exp_ready;
  } vec_t;

  vec_t tbl [24];

  int checks = 0;
  int passed = 0;

  localparam logic [127:0] EXP_A     = 128'h01020304070102030102030407010203;
  localparam logic [63:0]  EXP_B     = 64'h0506070809010203;
  localparam logic [127:0] EXP_A_10  = 128'h00000000000001020304070102030102;

  logic [7:0] stream [24] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd1, 8'd2, 8'd3,
                              8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd1, 8'd2, 8'd3,
                              8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: apply inputs at the falling edge, return at the next one.
  task automatic cycle(input logic [7:0] d, input logic v, input logic f, input logic r);
    bus.inData  = d;
    bus.inValid = v;
    bus.flush   = f;
    bus.resAck  = r;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].data, tbl[i].valid, 1'b0, 1'b0);
      check($sformatf("%s cnt[%0d]", tag, i), 128'(bus.loadCount), 128'(tbl[i].exp_count));
      check($sformatf("%s done[%0d]", tag, i), 128'(bus.loadDone), 128'(tbl[i].exp_done));
      check($sformatf("%s ready[%0d]", tag, i), 128'(bus.inReady), 128'(tbl[i].exp_ready));
      check($sformatf("%s mrst[%0d]", tag, i), 128'(bus.multRst), 128'(tbl[i].exp_done));
    end
    check({tag, " a"}, bus.a, EXP_A);
    check({tag, " b"}, 128'(bus.b), 128'(EXP_B));
  endtask

  initial begin
    // Expected table: counts step per accepted element and restart at the
    // A/B boundary and on completion; done/ready flip only on the 24th.
    for (int i = 0; i < 24; i++) begin
      tbl[i].data      = stream[i];
      tbl[i].valid     = 1'b1;
      if (i < 16) tbl[i].exp_count = (i == 15) ? 8'd0 : 8'(i + 1);
      else        tbl[i].exp_count = (i == 23) ? 8'd0 : 8'(i - 15);
      tbl[i].exp_done  = (i == 23);
      tbl[i].exp_ready = (i != 23);
    end

    bus.inData  = '0;
    bus.inValid = 1'b0;
    bus.flush   = 1'b0;
    bus.resAck  = 1'b0;

    // Reset hold
    @(negedge clk);
    @(negedge clk);
    check("rst a", bus.a, 128'h0);
    check("rst b", 128'(bus.b), 128'h0);
    check("rst cnt", 128'(bus.loadCount), 128'h0);
    check("rst mrst", 128'(bus.multRst), 128'h0);
    check("rst done", 128'(bus.loadDone), 128'h0);
    check("rst ready", 128'(bus.inReady), 128'h1);
    rst = 1'b1;

    // Back-to-back full load
    run_table("b2b");

    // RUN ignores the stream
    for (int i = 0; i < 5; i++) cycle(8'hFF, 1'b1, 1'b0, 1'b0);
    check("run a", bus.a, EXP_A);
    check("run b", 128'(bus.b), 128'(EXP_B));
    check("run cnt", 128'(bus.loadCount), 128'h0);
    check("run ready", 128'(bus.inReady), 128'h0);
    check("run done", 128'(bus.loadDone), 128'h1);

    // Result acknowledge re-arms, operands retained
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    check("ack mrst", 128'(bus.multRst), 128'h0);
    check("ack done", 128'(bus.loadDone), 128'h0);
    check("ack ready", 128'(bus.inReady), 128'h1);
    check("ack a held", bus.a, EXP_A);
    idle();

    // resAck outside RUN is ignored
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    check("ack idle ready", 128'(bus.inReady), 128'h1);
    check("ack idle cnt", 128'(bus.loadCount), 128'h0);

    // Stalled load: valid every other cycle, junk data on idle cycles
    for (int i = 0; i < 24; i++) begin
      cycle(stream[i], 1'b1, 1'b0, 1'b0);
      check($sformatf("stall done[%0d]", i), 128'(bus.loadDone), 128'(i == 23));
      check($sformatf("stall cnt[%0d]", i), 128'(bus.loadCount), 128'(tbl[i].exp_count));
      if (i != 23) begin
        cycle(8'hEE, 1'b0, 1'b0, 1'b0);
        check($sformatf("stall hold[%0d]", i), 128'(bus.loadCount), 128'(tbl[i].exp_count));
      end
    end
    check("stall a", bus.a, EXP_A);
    check("stall b", 128'(bus.b), 128'(EXP_B));

    // flush together with resAck in RUN
    cycle(8'h00, 1'b0, 1'b1, 1'b1);
    check("fl+ack a", bus.a, 128'h0);
    check("fl+ack b", 128'(bus.b), 128'h0);
    check("fl+ack cnt", 128'(bus.loadCount), 128'h0);
    check("fl+ack done", 128'(bus.loadDone), 128'h0);
    check("fl+ack mrst", 128'(bus.multRst), 128'h0);
    check("fl+ack ready", 128'(bus.inReady), 128'h1);

    // Flush after 10 A elements
    for (int i = 0; i < 10; i++) cycle(stream[i], 1'b1, 1'b0, 1'b0);
    check("pre-fl cnt", 128'(bus.loadCount), 128'd10);
    check("pre-fl a", bus.a, EXP_A_10);
    cycle(8'h00, 1'b0, 1'b1, 1'b0);
    check("fl10 a", bus.a, 128'h0);
    check("fl10 cnt", 128'(bus.loadCount), 128'h0);
    check("fl10 ready", 128'(bus.inReady), 128'h1);
    run_table("post-fl");

    // flush together with an element transfer
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(stream[i], 1'b1, 1'b0, 1'b0);
    check("fl+x pre cnt", 128'(bus.loadCount), 128'd3);
    cycle(8'hAA, 1'b1, 1'b1, 1'b0);
    check("fl+x a", bus.a, 128'h0);
    check("fl+x cnt", 128'(bus.loadCount), 128'h0);
    cycle(8'h55, 1'b1, 1'b0, 1'b0);
    check("post fl+x a", bus.a, 128'h55);
    check("post fl+x cnt", 128'(bus.loadCount), 128'd1);

    // Asynchronous reset during LOAD_B
    for (int i = 1; i < 19; i++) cycle(stream[i], 1'b1, 1'b0, 1'b0);
    check("mid B cnt", 128'(bus.loadCount), 128'd3);
    check("mid B b", 128'(bus.b), 128'h050607);
    idle();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst a", bus.a, 128'h0);
    check("arst b", 128'(bus.b), 128'h0);
    check("arst cnt", 128'(bus.loadCount), 128'h0);
    check("arst ready", 128'(bus.inReady), 128'h1);
    @(negedge clk);
    rst = 1'b1;
    idle();
    check("arst rel ready", 128'(bus.inReady), 128'h1);
    check("arst rel cnt", 128'(bus.loadCount), 128'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
